// File: rtl/arbiter_pkg.sv
// Shared FSM encodings and line-width derivation for multi_port_arbiter.
package arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int unsigned DEF_ADDR_W = 20;
    localparam int unsigned DEF_SHIFT  = 4;

    // Line width in bits: 2**shift bytes per bus beat.
    function automatic int unsigned line_dw(input int unsigned shift);
        return 32'd8 << shift;
    endfunction

    // Line address drops the byte-offset bits.
    function automatic int unsigned line_aw(input int unsigned addr_w, input int unsigned shift);
        return addr_w - shift;
    endfunction

    localparam int unsigned DEF_DW = line_dw(DEF_SHIFT);
    localparam int unsigned DEF_AW = line_aw(DEF_ADDR_W, DEF_SHIFT);

endpackage

// File: rtl/arb_picker.sv
// Winner selection: first requester searching upward (with wrap) from ptr_i+1.
// A pointer of NUM_PORTS-1 degenerates to lowest-index fixed priority.
module arb_picker #(
    parameter int unsigned NUM_PORTS = 2,
    localparam int unsigned IDX_W = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_PORTS-1:0] win_oh_o_c,
    output logic [IDX_W-1:0]     win_idx_o_c,
    output logic                 found_o_c
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        win_oh_o_c  = '0;
        win_idx_o_c = '0;
        found_o_c   = 1'b0;
        cand        = '0;
        for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
            cand = IDX_W'((32'(ptr_i) + off) % NUM_PORTS);
            if (!found_o_c && req_i[cand]) begin
                found_o_c        = 1'b1;
                win_oh_o_c[cand] = 1'b1;
                win_idx_o_c      = cand;
            end
        end
    end

endmodule

// File: rtl/multi_port_arbiter.sv
// Multi-port bus arbiter: IDLE -> BUSY -> RESP, one outstanding transaction.
// Define MULTI_PORT_ARBITER_ROUND_ROBIN_EN for round-robin; otherwise fixed priority.
module multi_port_arbiter
    import arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS            = 2,
    parameter int unsigned BUS_ADDRESS_WIDTH    = DEF_ADDR_W,
    parameter int unsigned BUS_DATA_WIDTH_SHIFT = DEF_SHIFT,
    localparam int unsigned DW = line_dw(BUS_DATA_WIDTH_SHIFT),
    localparam int unsigned AW = line_aw(BUS_ADDRESS_WIDTH, BUS_DATA_WIDTH_SHIFT)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_PORTS-1:0]    req_valid_i,
    input  logic [NUM_PORTS-1:0]    req_we_i,
    input  logic [NUM_PORTS*AW-1:0] req_addr_i,
    input  logic [NUM_PORTS*DW-1:0] req_data_i,
    output logic [NUM_PORTS-1:0]    resp_valid_o,
    output logic [NUM_PORTS-1:0]    grant_o,
    output logic [AW-1:0]           bus_addr_o,
    output logic [DW-1:0]           bus_data_o,
    output logic                    bus_we_o,
    output logic                    bus_valid_o,
    input  logic                    bus_valid_i
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    logic [1:0]           state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [NUM_PORTS-1:0] resp_q, resp_d;
    logic                 bus_valid_q, bus_valid_d;
    logic                 bus_we_q, bus_we_d;
    logic [AW-1:0]        bus_addr_q, bus_addr_d;
    logic [DW-1:0]        bus_data_q, bus_data_d;

    logic [NUM_PORTS-1:0] win_oh;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     ptr_sel;
    logic                 found;

`ifdef MULTI_PORT_ARBITER_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Pointer tracks the last granted port.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ST_IDLE && found) begin
            ptr_d = win_idx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr_q <= IDX_W'(NUM_PORTS - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_sel = ptr_q;
`else
    assign ptr_sel = IDX_W'(NUM_PORTS - 1);
`endif

    arb_picker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_picker (
        .req_i       (req_valid_i),
        .ptr_i       (ptr_sel),
        .win_oh_o_c  (win_oh),
        .win_idx_o_c (win_idx),
        .found_o_c   (found)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        resp_d      = '0;
        bus_valid_d = bus_valid_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_data_d  = bus_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d     = ST_BUSY;
                    grant_d     = win_oh;
                    bus_valid_d = 1'b1;
                    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                        if (win_idx == IDX_W'(k)) begin
                            bus_we_d   = req_we_i[k];
                            bus_addr_d = req_addr_i[k*AW +: AW];
                            bus_data_d = req_data_i[k*DW +: DW];
                        end
                    end
                end
            end
            ST_BUSY: begin
                if (bus_valid_i) begin
                    state_d     = ST_RESP;
                    resp_d      = grant_q;
                    bus_valid_d = 1'b0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d     = ST_IDLE;
                grant_d     = '0;
                bus_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            resp_q      <= '0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            resp_q      <= resp_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_data_q  <= bus_data_d;
        end
    end

    assign resp_valid_o = resp_q;
    assign grant_o      = grant_q;
    assign bus_valid_o  = bus_valid_q;
    assign bus_we_o     = bus_we_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_data_o   = bus_data_q;

endmodule

// File: tb/tb_multi_port_arbiter.sv
// Directed bench for multi_port_arbiter: 2-port and 4-port instances.
// Expected grant orders follow MULTI_PORT_ARBITER_ROUND_ROBIN_EN when defined.
module tb_multi_port_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 128;

    logic clk;
    logic rst_n;

    logic [1:0]      r2_valid, r2_we;
    logic [2*AW-1:0] r2_addr;
    logic [2*DW-1:0] r2_data;
    logic [1:0]      rsp2, gnt2;
    logic [AW-1:0]   baddr2;
    logic [DW-1:0]   bdata2;
    logic            bwe2, bvo2, bvi2;

    logic [3:0]      r4_valid, r4_we;
    logic [4*AW-1:0] r4_addr;
    logic [4*DW-1:0] r4_data;
    logic [3:0]      rsp4, gnt4;
    logic [AW-1:0]   baddr4;
    logic [DW-1:0]   bdata4;
    logic            bwe4, bvo4, bvi4;

    int n_chk;
    int n_err;

    multi_port_arbiter #(.NUM_PORTS(2)) dut2 (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .req_valid_i  (r2_valid),
        .req_we_i     (r2_we),
        .req_addr_i   (r2_addr),
        .req_data_i   (r2_data),
        .resp_valid_o (rsp2),
        .grant_o      (gnt2),
        .bus_addr_o   (baddr2),
        .bus_data_o   (bdata2),
        .bus_we_o     (bwe2),
        .bus_valid_o  (bvo2),
        .bus_valid_i  (bvi2)
    );

    multi_port_arbiter #(.NUM_PORTS(4)) dut4 (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .req_valid_i  (r4_valid),
        .req_we_i     (r4_we),
        .req_addr_i   (r4_addr),
        .req_data_i   (r4_data),
        .resp_valid_o (rsp4),
        .grant_o      (gnt4),
        .bus_addr_o   (baddr4),
        .bus_data_o   (bdata4),
        .bus_we_o     (bwe4),
        .bus_valid_o  (bvo4),
        .bus_valid_i  (bvi4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        r2_valid = '0; r2_we = '0; r2_addr = '0; r2_data = '0; bvi2 = 1'b0;
        r4_valid = '0; r4_we = '0; r4_addr = '0; r4_data = '0; bvi4 = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Grant, immediate bus completion, RESP pulse, back to IDLE.
    task automatic txn2(input string tag, input logic [1:0] exp_g, input logic [AW-1:0] exp_a);
        tick();
        check_eq({tag, "_grant"}, 128'(gnt2), 128'(exp_g));
        check_eq({tag, "_bvo"}, 128'(bvo2), 128'(1'b1));
        check_eq({tag, "_addr"}, 128'(baddr2), 128'(exp_a));
        bvi2 = 1'b1;
        tick();
        bvi2 = 1'b0;
        check_eq({tag, "_resp"}, 128'(rsp2), 128'(exp_g));
        check_eq({tag, "_bvo_drop"}, 128'(bvo2), 128'(1'b0));
        tick();
        check_eq({tag, "_resp_end"}, 128'(rsp2), 128'(2'b00));
        check_eq({tag, "_grant_idle"}, 128'(gnt2), 128'(2'b00));
    endtask

    task automatic txn4(input string tag, input logic [3:0] exp_g, input logic [AW-1:0] exp_a);
        tick();
        check_eq({tag, "_grant"}, 128'(gnt4), 128'(exp_g));
        check_eq({tag, "_addr"}, 128'(baddr4), 128'(exp_a));
        bvi4 = 1'b1;
        tick();
        bvi4 = 1'b0;
        check_eq({tag, "_resp"}, 128'(rsp4), 128'(exp_g));
        tick();
        check_eq({tag, "_grant_idle"}, 128'(gnt4), 128'(4'b0000));
    endtask

    logic [1:0]    ord2 [4];
    logic [3:0]    ord4 [3];
    logic [AW-1:0] a2 [2];
    logic [AW-1:0] a4 [4];
    logic [DW-1:0] wdata;

    initial begin
        n_chk = 0;
        n_err = 0;
`ifdef MULTI_PORT_ARBITER_ROUND_ROBIN_EN
        ord2[0] = 2'b01; ord2[1] = 2'b10; ord2[2] = 2'b01; ord2[3] = 2'b10;
        ord4[0] = 4'b0010; ord4[1] = 4'b1000; ord4[2] = 4'b0010;
`else
        ord2[0] = 2'b01; ord2[1] = 2'b01; ord2[2] = 2'b01; ord2[3] = 2'b01;
        ord4[0] = 4'b0010; ord4[1] = 4'b0010; ord4[2] = 4'b0010;
`endif
        a2[0] = 16'h0100; a2[1] = 16'h0200;
        a4[0] = 16'h0000; a4[1] = 16'h0111; a4[2] = 16'h0222; a4[3] = 16'h0333;
        wdata = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;

        // Reset values while held in reset.
        clear_inputs();
        rst_n = 1'b0;
        tick();
        check_eq("rst_grant", 128'(gnt2), 128'(2'b00));
        check_eq("rst_resp", 128'(rsp2), 128'(2'b00));
        check_eq("rst_bvo", 128'(bvo2), 128'(1'b0));
        check_eq("rst_we", 128'(bwe2), 128'(1'b0));
        check_eq("rst_addr", 128'(baddr2), 128'(0));
        check_eq("rst_data", 128'(bdata2), 128'(0));

        // Single read from port 0, bus completes two cycles after bus_valid_o.
        do_reset();
        r2_valid = 2'b01;
        r2_addr  = {16'h0000, 16'h0123};
        tick();
        check_eq("single_bvo", 128'(bvo2), 128'(1'b1));
        check_eq("single_addr", 128'(baddr2), 128'(16'h0123));
        check_eq("single_we", 128'(bwe2), 128'(1'b0));
        check_eq("single_grant", 128'(gnt2), 128'(2'b01));
        tick();
        check_eq("single_wait_bvo", 128'(bvo2), 128'(1'b1));
        check_eq("single_wait_resp", 128'(rsp2), 128'(2'b00));
        bvi2 = 1'b1;
        tick();
        bvi2 = 1'b0;
        check_eq("single_resp", 128'(rsp2), 128'(2'b01));
        check_eq("single_bvo_drop", 128'(bvo2), 128'(1'b0));
        tick();
        r2_valid = 2'b00;
        check_eq("single_resp_1cyc", 128'(rsp2), 128'(2'b00));
        check_eq("single_grant_clr", 128'(gnt2), 128'(2'b00));

        // Both ports held for four transactions.
        do_reset();
        r2_valid = 2'b11;
        r2_addr  = {a2[1], a2[0]};
        for (int i = 0; i < 4; i++) begin
            txn2($sformatf("both%0d", i), ord2[i], ord2[i][1] ? a2[1] : a2[0]);
        end
        r2_valid = 2'b00;

        // Write snapshot held while the requester changes its data.
        do_reset();
        r2_valid = 2'b10;
        r2_we    = 2'b10;
        r2_addr  = {16'h0456, 16'h0000};
        r2_data  = {wdata, 128'h0};
        tick();
        check_eq("wr_grant", 128'(gnt2), 128'(2'b10));
        check_eq("wr_we", 128'(bwe2), 128'(1'b1));
        check_eq("wr_data", 128'(bdata2), wdata);
        r2_data = {128'h0123_4567, 128'h0};
        r2_addr = {16'h0999, 16'h0000};
        r2_we   = 2'b00;
        tick();
        check_eq("wr_hold_data", 128'(bdata2), wdata);
        check_eq("wr_hold_addr", 128'(baddr2), 128'(16'h0456));
        check_eq("wr_hold_we", 128'(bwe2), 128'(1'b1));
        bvi2 = 1'b1;
        tick();
        bvi2 = 1'b0;
        check_eq("wr_resp", 128'(rsp2), 128'(2'b10));
        check_eq("wr_resp_data", 128'(bdata2), wdata);
        tick();
        r2_valid = 2'b00;

        // Spurious bus_valid_i in IDLE, then a request still gets 1-cycle latency.
        do_reset();
        bvi2 = 1'b1;
        tick();
        check_eq("spur_resp0", 128'(rsp2), 128'(2'b00));
        check_eq("spur_bvo0", 128'(bvo2), 128'(1'b0));
        tick();
        check_eq("spur_resp1", 128'(rsp2), 128'(2'b00));
        check_eq("spur_grant", 128'(gnt2), 128'(2'b00));
        bvi2 = 1'b0;
        r2_valid = 2'b10;
        r2_addr  = {16'h00AB, 16'h0000};
        tick();
        check_eq("spur_then_bvo", 128'(bvo2), 128'(1'b1));
        check_eq("spur_then_grant", 128'(gnt2), 128'(2'b10));
        bvi2 = 1'b1;
        tick();
        bvi2 = 1'b0;
        check_eq("spur_then_resp", 128'(rsp2), 128'(2'b10));
        tick();
        r2_valid = 2'b00;

        // Asynchronous reset in the middle of BUSY abandons the transaction.
        do_reset();
        r2_valid = 2'b01;
        r2_addr  = {16'h0000, 16'h0077};
        tick();
        check_eq("mid_bvo", 128'(bvo2), 128'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_bvo", 128'(bvo2), 128'(1'b0));
        check_eq("mid_rst_grant", 128'(gnt2), 128'(2'b00));
        check_eq("mid_rst_addr", 128'(baddr2), 128'(0));
        bvi2     = 1'b1;
        r2_valid = 2'b00;
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("mid_post_resp0", 128'(rsp2), 128'(2'b00));
        check_eq("mid_post_bvo", 128'(bvo2), 128'(1'b0));
        tick();
        check_eq("mid_post_resp1", 128'(rsp2), 128'(2'b00));
        bvi2 = 1'b0;

        // Four-port instance with ports 1 and 3 requesting.
        do_reset();
        r4_valid = 4'b1010;
        r4_addr  = {a4[3], a4[2], a4[1], a4[0]};
        for (int i = 0; i < 3; i++) begin
            txn4($sformatf("p4_%0d", i), ord4[i], ord4[i][3] ? a4[3] : a4[1]);
        end
        r4_valid = 4'b0000;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
